// File: rtl/fp_addsub_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// fp_addsub_arbiter - round-robin sharing of one FP add/sub unit
// Revision: 1.0
// ------------------------------------------------------------------------
module fp_addsub_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned FP_WIDTH     = 32,
  parameter int unsigned RND_WIDTH    = 3,
  parameter int unsigned STAT_WIDTH   = 5,
  parameter int unsigned TAG_WIDTH    = 2,
  parameter int unsigned UNIT_LAT     = 0,
  parameter int unsigned MAX_INFLIGHT = UNIT_LAT + 1,
  parameter int unsigned ID_WIDTH     = $clog2(NREQ),
  parameter int unsigned CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NREQ-1:0]                     req_i,
  output logic [NREQ-1:0]                     gnt_o,
  input  logic [NREQ-1:0][FP_WIDTH-1:0]       opa_i,
  input  logic [NREQ-1:0][FP_WIDTH-1:0]       opb_i,
  input  logic [NREQ-1:0]                     subsel_i,
  input  logic [NREQ-1:0][RND_WIDTH-1:0]      rnd_i,
  input  logic [NREQ-1:0][TAG_WIDTH-1:0]      tag_i,
  output logic [NREQ-1:0]                     resp_valid_o,
  output logic [FP_WIDTH-1:0]                 resp_res_o,
  output logic [STAT_WIDTH-1:0]               resp_status_o,
  output logic [TAG_WIDTH-1:0]                resp_tag_o,
  output logic                                unit_en_o,
  output logic                                unit_subsel_o,
  output logic [FP_WIDTH-1:0]                 unit_opa_o,
  output logic [FP_WIDTH-1:0]                 unit_opb_o,
  output logic [RND_WIDTH-1:0]                unit_rnd_o,
  output logic [ID_WIDTH+TAG_WIDTH-1:0]       unit_tag_o,
  input  logic                                unit_ready_i,
  input  logic                                unit_valid_i,
  input  logic [FP_WIDTH-1:0]                 unit_res_i,
  input  logic [STAT_WIDTH-1:0]               unit_status_i,
  input  logic [ID_WIDTH+TAG_WIDTH-1:0]       unit_tag_i,
  output logic [CNT_WIDTH-1:0]                inflight_o,
  output logic                                idle_o,
  output logic                                err_o
);

  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]  inflight_q, inflight_d;
  logic                  err_q, err_d;
  logic [NREQ-1:0]       resp_valid_q, resp_valid_d;
  logic [FP_WIDTH-1:0]   resp_res_q, resp_res_d;
  logic [STAT_WIDTH-1:0] resp_status_q, resp_status_d;
  logic [TAG_WIDTH-1:0]  resp_tag_q, resp_tag_d;

  logic                  allow;
  logic                  issue;
  logic [NREQ-1:0]       req_upper;
  logic [NREQ-1:0]       pick;
  logic [ID_WIDTH-1:0]   winner;
  logic [NREQ-1:0]       gnt;
  logic [ID_WIDTH-1:0]   ret_id;
  logic                  spurious;
  logic                  bad_id;

  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    allow     = rst_ni && unit_ready_i && (inflight_q < CNT_WIDTH'(MAX_INFLIGHT));
    req_upper = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_upper[i] = req_i[i] && (ID_WIDTH'(i) >= rr_ptr_q);
    end
    pick   = (req_upper != '0) ? req_upper : req_i;
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick[i]) winner = ID_WIDTH'(i);
    end
    issue = allow && (req_i != '0);
    gnt   = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = issue && (winner == ID_WIDTH'(i));
    end
  end

  always_comb begin
    unit_subsel_o = 1'b0;
    unit_opa_o    = '0;
    unit_opb_o    = '0;
    unit_rnd_o    = '0;
    unit_tag_o    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        unit_subsel_o = subsel_i[i];
        unit_opa_o    = opa_i[i];
        unit_opb_o    = opb_i[i];
        unit_rnd_o    = rnd_i[i];
        unit_tag_o    = {ID_WIDTH'(i), tag_i[i]};
      end
    end
  end

  always_comb begin
    ret_id = unit_tag_i[ID_WIDTH+TAG_WIDTH-1 -: ID_WIDTH];

    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (winner == ID_WIDTH'(NREQ - 1)) ? '0 : winner + ID_WIDTH'(1);
    end

    // An issue and a return in the same cycle cancel, so a zero-latency unit never looks spurious.
    spurious = unit_valid_i && (inflight_q == '0) && !issue;
    bad_id   = unit_valid_i && (32'(ret_id) >= NREQ);
    err_d    = err_q || spurious || bad_id;

    inflight_d = inflight_q;
    if (issue && !unit_valid_i) begin
      inflight_d = inflight_q + CNT_WIDTH'(1);
    end else if (!issue && unit_valid_i && (inflight_q != '0)) begin
      inflight_d = inflight_q - CNT_WIDTH'(1);
    end

    resp_valid_d  = '0;
    resp_res_d    = resp_res_q;
    resp_status_d = resp_status_q;
    resp_tag_d    = resp_tag_q;
    if (unit_valid_i) begin
      for (int i = 0; i < NREQ; i++) begin
        resp_valid_d[i] = (ret_id == ID_WIDTH'(i));
      end
      resp_res_d    = unit_res_i;
      resp_status_d = unit_status_i;
      resp_tag_d    = unit_tag_i[TAG_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q      <= '0;
      inflight_q    <= '0;
      err_q         <= 1'b0;
      resp_valid_q  <= '0;
      resp_res_q    <= '0;
      resp_status_q <= '0;
      resp_tag_q    <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      inflight_q    <= inflight_d;
      err_q         <= err_d;
      resp_valid_q  <= resp_valid_d;
      resp_res_q    <= resp_res_d;
      resp_status_q <= resp_status_d;
      resp_tag_q    <= resp_tag_d;
    end
  end

  assign gnt_o         = gnt;
  assign unit_en_o     = issue;
  assign resp_valid_o  = resp_valid_q;
  assign resp_res_o    = resp_res_q;
  assign resp_status_o = resp_status_q;
  assign resp_tag_o    = resp_tag_q;
  assign inflight_o    = inflight_q;
  assign err_o         = err_q;
  assign idle_o        = (req_i == '0) && (inflight_q == '0);

endmodule
`default_nettype wire
